// File: rtl/btb_pkg.sv
// Shared types and constants for the 2-way branch target buffer.
package btb_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   localparam logic [1:0] CTR_MIN        = 2'b00;
   localparam logic [1:0] CTR_WEAK_TAKEN = 2'b10;
   localparam logic [1:0] CTR_MAX        = 2'b11;

endpackage

// File: rtl/sat_ctr2.sv
// 2-bit saturating direction counter: next value from current value and outcome.
module sat_ctr2
   import btb_pkg::*;
(
   input  logic [1:0] i_ctr,
   input  logic       i_taken,
   output logic [1:0] o_ctr
);

   // Step toward the outcome, holding at either end of the range.
   always_comb begin
      o_ctr = i_ctr;
      if (i_taken) begin
         if (i_ctr != CTR_MAX) o_ctr = i_ctr + 2'd1;
      end else begin
         if (i_ctr != CTR_MIN) o_ctr = i_ctr - 2'd1;
      end
   end

endmodule

// File: rtl/btb_assoc.sv
// 2-way set-associative BTB with two combinational lookup slots, one update
// port and a one-set-per-cycle flush sweep.
//
// state | meaning
// IDLE  | normal operation, lookups and updates allowed
// FLUSH | sweeping sets 0..SETS-1, hits forced low, updates dropped
module btb_assoc
   import btb_pkg::*;
#(
   parameter int PC_W  = 15,
   parameter int IDX_W = 4,
   parameter int TAG_W = PC_W - IDX_W - 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [PC_W-1:0] pc1,
   input  logic [PC_W-1:0] pc2,
   output logic            btb_hit1,
   output logic            btb_hit2,
   output logic            pred_taken1,
   output logic            pred_taken2,
   output logic [PC_W-1:0] pred_pc1,
   output logic [PC_W-1:0] pred_pc2,
   input  logic            upd_valid,
   input  logic [PC_W-1:0] upd_pc,
   input  logic [PC_W-1:0] upd_target,
   input  logic            upd_taken,
   input  logic            flush,
   output logic            busy
);

   localparam int SETS = 2**IDX_W;

   // Per-way storage, indexed [way][set].
   logic             r_valid [2][SETS];
   logic [TAG_W-1:0] r_tag   [2][SETS];
   logic [PC_W-1:0]  r_tgt   [2][SETS];
   logic [1:0]       r_ctr   [2][SETS];
   logic             r_lru   [SETS];

   state_t           r_state;
   logic [IDX_W-1:0] r_sweep;

   logic [PC_W-1:0]  w_lk_pc  [2];
   logic             w_lk_hit [2];
   logic             w_lk_tk  [2];
   logic [PC_W-1:0]  w_lk_tgt [2];

   logic [IDX_W-1:0] w_uidx;
   logic [TAG_W-1:0] w_utag;
   logic             w_um0;
   logic             w_um1;
   logic             w_uhit;
   logic             w_uway;
   logic             w_alloc_way;
   logic             w_upd_ok;
   logic [1:0]       w_uctr_new;
   logic             w_unused_lsbs;

   assign busy = (r_state == ST_FLUSH);

   // Byte offset bits never take part in index or tag.
   assign w_unused_lsbs = ^{pc1[1:0], pc2[1:0], upd_pc[1:0]};

   assign w_lk_pc[0] = pc1;
   assign w_lk_pc[1] = pc2;

   // Read-only lookup for both slots; way0 wins if both ways match.
   always_comb begin
      for (int s = 0; s < 2; s++) begin
         logic [IDX_W-1:0] v_idx;
         logic [TAG_W-1:0] v_tag;
         logic             v_m0;
         logic             v_m1;
         v_idx = w_lk_pc[s][IDX_W+1:2];
         v_tag = w_lk_pc[s][PC_W-1:IDX_W+2];
         v_m0  = r_valid[0][v_idx] && (r_tag[0][v_idx] == v_tag);
         v_m1  = r_valid[1][v_idx] && (r_tag[1][v_idx] == v_tag);
         w_lk_hit[s] = (v_m0 || v_m1) && !busy;
         w_lk_tk[s]  = w_lk_hit[s] && (v_m0 ? r_ctr[0][v_idx][1] : r_ctr[1][v_idx][1]);
         w_lk_tgt[s] = '0;
         if (w_lk_hit[s]) w_lk_tgt[s] = v_m0 ? r_tgt[0][v_idx] : r_tgt[1][v_idx];
      end
   end

   assign btb_hit1    = w_lk_hit[0];
   assign btb_hit2    = w_lk_hit[1];
   assign pred_taken1 = w_lk_tk[0];
   assign pred_taken2 = w_lk_tk[1];
   assign pred_pc1    = w_lk_tgt[0];
   assign pred_pc2    = w_lk_tgt[1];

   assign w_uidx      = upd_pc[IDX_W+1:2];
   assign w_utag      = upd_pc[PC_W-1:IDX_W+2];
   assign w_um0       = r_valid[0][w_uidx] && (r_tag[0][w_uidx] == w_utag);
   assign w_um1       = r_valid[1][w_uidx] && (r_tag[1][w_uidx] == w_utag);
   assign w_uhit      = w_um0 || w_um1;
   assign w_uway      = w_um0 ? 1'b0 : 1'b1;
   assign w_alloc_way = !r_valid[0][w_uidx] ? 1'b0 :
                        !r_valid[1][w_uidx] ? 1'b1 : r_lru[w_uidx];
   assign w_upd_ok    = upd_valid && !flush && (r_state == ST_IDLE);

   sat_ctr2 u_sat_ctr2 (
      .i_ctr   (r_ctr[w_uway][w_uidx]),
      .i_taken (upd_taken),
      .o_ctr   (w_uctr_new)
   );

   // Flush FSM, sweep clearing and resolved-branch updates.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_sweep <= '0;
         for (int s = 0; s < SETS; s++) begin
            r_lru[s] <= 1'b0;
            for (int w = 0; w < 2; w++) begin
               r_valid[w][s] <= 1'b0;
               r_ctr[w][s]   <= CTR_MIN;
            end
         end
      end else begin
         if (r_state == ST_FLUSH) begin
            r_lru[r_sweep] <= 1'b0;
            for (int w = 0; w < 2; w++) begin
               r_valid[w][r_sweep] <= 1'b0;
               r_ctr[w][r_sweep]   <= CTR_MIN;
            end
         end

         if (flush) begin
            r_state <= ST_FLUSH;
            r_sweep <= '0;
         end else if (r_state == ST_FLUSH) begin
            if (r_sweep == '1) r_state <= ST_IDLE;
            r_sweep <= r_sweep + 1'b1;
         end

         if (w_upd_ok) begin
            if (w_uhit) begin
               r_ctr[w_uway][w_uidx] <= w_uctr_new;
               if (upd_taken) r_tgt[w_uway][w_uidx] <= upd_target;
               r_lru[w_uidx] <= ~w_uway;
            end else if (upd_taken) begin
               r_valid[w_alloc_way][w_uidx] <= 1'b1;
               r_tag[w_alloc_way][w_uidx]   <= w_utag;
               r_tgt[w_alloc_way][w_uidx]   <= upd_target;
               r_ctr[w_alloc_way][w_uidx]   <= CTR_WEAK_TAKEN;
               r_lru[w_uidx]                <= ~w_alloc_way;
            end
         end
      end
   end

endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc: expectations are queued when a step is
// driven and popped against the DUT outputs mid-cycle.
module tb_btb_assoc;

   localparam int PC_W = 15;

   logic            clk = 1'b0;
   logic            rst;
   logic [PC_W-1:0] pc1, pc2;
   logic            btb_hit1, btb_hit2;
   logic            pred_taken1, pred_taken2;
   logic [PC_W-1:0] pred_pc1, pred_pc2;
   logic            upd_valid;
   logic [PC_W-1:0] upd_pc, upd_target;
   logic            upd_taken;
   logic            flush;
   logic            busy;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] exp;
   } sb_item_t;

   sb_item_t sb_q[$];

   always #5 clk = ~clk;

   btb_assoc #(.PC_W(15), .IDX_W(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .pc1         (pc1),
      .pc2         (pc2),
      .btb_hit1    (btb_hit1),
      .btb_hit2    (btb_hit2),
      .pred_taken1 (pred_taken1),
      .pred_taken2 (pred_taken2),
      .pred_pc1    (pred_pc1),
      .pred_pc2    (pred_pc2),
      .upd_valid   (upd_valid),
      .upd_pc      (upd_pc),
      .upd_target  (upd_target),
      .upd_taken   (upd_taken),
      .flush       (flush),
      .busy        (busy)
   );

   function automatic logic [31:0] observe(int sel);
      case (sel)
         0: return {31'b0, btb_hit1};
         1: return {31'b0, pred_taken1};
         2: return {17'b0, pred_pc1};
         3: return {31'b0, btb_hit2};
         4: return {31'b0, pred_taken2};
         5: return {17'b0, pred_pc2};
         default: return {31'b0, busy};
      endcase
   endfunction

   task automatic push(string tag, int sel, logic [31:0] e);
      sb_item_t it;
      it.tag = tag;
      it.sel = sel;
      it.exp = e;
      sb_q.push_back(it);
   endtask

   task automatic exp_lk(string tag, logic h1, logic t1, logic [31:0] p1,
                         logic h2, logic t2, logic [31:0] p2, logic b);
      push({tag, ".hit1"}, 0, {31'b0, h1});
      push({tag, ".taken1"}, 1, {31'b0, t1});
      push({tag, ".pc1"}, 2, p1);
      push({tag, ".hit2"}, 3, {31'b0, h2});
      push({tag, ".taken2"}, 4, {31'b0, t2});
      push({tag, ".pc2"}, 5, p2);
      push({tag, ".busy"}, 6, {31'b0, b});
   endtask

   task automatic exp_busy(string tag, logic b);
      push({tag, ".busy"}, 6, {31'b0, b});
   endtask

   // Called at posedge+1: settle to mid-cycle, then drain the scoreboard.
   task automatic sample();
      sb_item_t    it;
      logic [31:0] o;
      #4;
      while (sb_q.size() > 0) begin
         it = sb_q.pop_front();
         o  = observe(it.sel);
         n_assert++;
         assert (o === it.exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", it.tag, o, it.exp);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic look(logic [PC_W-1:0] a, logic [PC_W-1:0] b);
      pc1 = a;
      pc2 = b;
   endtask

   task automatic upd(logic [PC_W-1:0] pc, logic [PC_W-1:0] tgt, logic tk);
      upd_valid  = 1'b1;
      upd_pc     = pc;
      upd_target = tgt;
      upd_taken  = tk;
   endtask

   task automatic upd_off();
      upd_valid = 1'b0;
   endtask

   // One update committed in its own cycle.
   task automatic upd_cycle(logic [PC_W-1:0] pc, logic [PC_W-1:0] tgt, logic tk);
      upd(pc, tgt, tk);
      step();
      upd_off();
   endtask

   localparam logic [PC_W-1:0] PC_A = 15'h0040;
   localparam logic [PC_W-1:0] PC_B = 15'h1F40;
   localparam logic [PC_W-1:0] PC_C = 15'h2040;
   localparam logic [PC_W-1:0] PC_E = 15'h0054;
   localparam logic [PC_W-1:0] PC_D = 15'h0058;
   localparam logic [PC_W-1:0] PC_F = 15'h0048;

   initial begin
      rst = 1'b1; flush = 1'b0;
      upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0;
      pc1 = '0; pc2 = '0;
      #1;
      step();
      step();
      rst = 1'b0;

      // Empty table after reset.
      look(PC_A, PC_B);
      exp_lk("reset", 0, 0, 0, 0, 0, 0, 0);
      sample();
      step();

      // Allocate A; same-cycle lookup still sees the old contents.
      upd(PC_A, 15'h0100, 1'b1);
      exp_lk("same_cycle", 0, 0, 0, 0, 0, 0, 0);
      sample();
      step();
      upd_off();
      exp_lk("after_alloc", 1, 1, 15'h0100, 0, 0, 0, 0);
      sample();

      // B fills way1, C evicts the LRU way (A).
      upd_cycle(PC_B, 15'h0200, 1'b1);
      upd_cycle(PC_C, 15'h0300, 1'b1);
      look(PC_A, PC_B);
      exp_lk("evict_AB", 0, 0, 0, 1, 1, 15'h0200, 0);
      sample();
      look(PC_C, PC_B);
      exp_lk("evict_CB", 1, 1, 15'h0300, 1, 1, 15'h0200, 0);
      sample();

      // Counter walk on C: 2 -> 1 -> 0 -> 0, target kept on not-taken.
      upd_cycle(PC_C, 15'h0777, 1'b0);
      exp_lk("nt1", 1, 0, 15'h0300, 1, 1, 15'h0200, 0);
      sample();
      upd_cycle(PC_C, 15'h0777, 1'b0);
      exp_lk("nt2", 1, 0, 15'h0300, 1, 1, 15'h0200, 0);
      sample();
      upd_cycle(PC_C, 15'h0777, 1'b0);
      exp_lk("nt3_sat0", 1, 0, 15'h0300, 1, 1, 15'h0200, 0);
      sample();
      // 0 -> 1 -> 2 -> 3 -> 3, target overwritten on taken.
      upd_cycle(PC_C, 15'h0310, 1'b1);
      exp_lk("t1", 1, 0, 15'h0310, 1, 1, 15'h0200, 0);
      sample();
      upd_cycle(PC_C, 15'h0310, 1'b1);
      exp_lk("t2", 1, 1, 15'h0310, 1, 1, 15'h0200, 0);
      sample();
      upd_cycle(PC_C, 15'h0310, 1'b1);
      exp_lk("t3", 1, 1, 15'h0310, 1, 1, 15'h0200, 0);
      sample();
      upd_cycle(PC_C, 15'h0310, 1'b1);
      upd_cycle(PC_C, 15'h0777, 1'b0);
      exp_lk("sat3_then_nt", 1, 1, 15'h0310, 1, 1, 15'h0200, 0);
      sample();

      // Add E in set 5, then flush with a coincident update of D.
      upd_cycle(PC_E, 15'h0400, 1'b1);
      look(PC_C, PC_E);
      flush = 1'b1;
      upd(PC_D, 15'h0500, 1'b1);
      exp_lk("flush_req", 1, 1, 15'h0310, 1, 1, 15'h0400, 0);
      sample();
      step();
      flush = 1'b0;
      upd_off();
      for (int c = 0; c < 16; c++) begin
         if (c == 8) upd(PC_F, 15'h0600, 1'b1);
         else upd_off();
         exp_lk($sformatf("sweep%0d", c), 0, 0, 0, 0, 0, 0, 1);
         sample();
         step();
      end
      upd_off();
      exp_lk("post_flush_CE", 0, 0, 0, 0, 0, 0, 0);
      sample();
      look(PC_B, PC_D);
      exp_lk("post_flush_BD", 0, 0, 0, 0, 0, 0, 0);
      sample();
      look(PC_F, PC_A);
      exp_lk("post_flush_FA", 0, 0, 0, 0, 0, 0, 0);
      sample();

      // Reset at sweep cycle 5 aborts the sweep and clears the table.
      upd_cycle(PC_E, 15'h0400, 1'b1);
      look(PC_E, PC_B);
      exp_lk("pre_rst_flush", 1, 1, 15'h0400, 0, 0, 0, 0);
      sample();
      flush = 1'b1;
      step();
      flush = 1'b0;
      for (int c = 0; c < 5; c++) begin
         exp_busy($sformatf("rst_sweep%0d", c), 1);
         sample();
         step();
      end
      rst = 1'b1;
      exp_busy("rst_sweep5", 1);
      sample();
      step();
      rst = 1'b0;
      exp_lk("after_rst_abort", 0, 0, 0, 0, 0, 0, 0);
      sample();

      // Reset beats a simultaneous flush and update.
      rst = 1'b1;
      flush = 1'b1;
      upd(PC_E, 15'h0400, 1'b1);
      step();
      rst = 1'b0;
      flush = 1'b0;
      upd_off();
      exp_lk("rst_wins", 0, 0, 0, 0, 0, 0, 0);
      sample();

      // Flush re-issued at sweep cycle 3 restarts the full 16-cycle sweep.
      flush = 1'b1;
      step();
      flush = 1'b0;
      for (int c = 0; c < 3; c++) begin
         exp_busy($sformatf("pre_restart%0d", c), 1);
         sample();
         step();
      end
      flush = 1'b1;
      exp_busy("restart_req", 1);
      sample();
      step();
      flush = 1'b0;
      for (int c = 0; c < 16; c++) begin
         exp_busy($sformatf("restart%0d", c), 1);
         sample();
         step();
      end
      exp_busy("restart_done", 0);
      sample();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/btb_assoc.md
BTB_ASSOC -- requirements
Module: btb_assoc

Interface
REQ-001 SHALL have parameter PC_W, default 15, meaning PC/target width in bits.
REQ-002 SHALL have parameter IDX_W, default 4, meaning set-index width; sets = 2**IDX_W, 2 ways per set.
REQ-003 SHALL have parameter TAG_W, default PC_W-IDX_W-2, meaning stored tag width.
REQ-004 SHALL have the clock and reset ports: clk input 1 (single clock; rising edge), and rst input 1 (reset is synchronous and active-high).
REQ-005 SHALL have port pc1 input PC_W: lookup address, slot 1.
REQ-006 SHALL have port pc2 input PC_W: lookup address, slot 2.
REQ-007 SHALL have outputs btb_hit1 and btb_hit2, each 1 bit: valid tag match for each slot.
REQ-008 SHALL have outputs pred_taken1 and pred_taken2, each 1 bit: hit AND counter[1].
REQ-009 SHALL have outputs pred_pc1 and pred_pc2, each PC_W bits: stored target of the hitting way, else 0.
REQ-010 SHALL have input upd_valid, 1 bit: resolved-branch update strobe.
REQ-011 SHALL have inputs upd_pc and upd_target, each PC_W bits: resolved branch PC and target.
REQ-012 SHALL have input upd_taken, 1 bit: resolved branch outcome.
REQ-013 SHALL have input flush, 1 bit: request full invalidation.
REQ-014 SHALL have output busy, 1 bit: high while the flush sweep runs.

Function
REQ-015 Index SHALL be pc[IDX_W+1:2], tag SHALL be pc[PC_W-1:IDX_W+2], and pc[1:0] SHALL be ignored.
REQ-016 Lookups SHALL be combinational, read-only, and SHALL NOT alter LRU or counters.
REQ-017 While busy=1, btb_hit1/2 SHALL be 0.
REQ-018 Each entry SHALL hold {valid, tag, target, 2-bit saturating counter}, and each set SHALL hold 1 LRU bit naming the victim way.
REQ-019 On an update hit, the counter SHALL move +1 if taken (saturating at 3) or -1 if not taken (saturating at 0), the target SHALL be overwritten only if taken, and LRU SHALL point to the other way.
REQ-020 On an update miss with taken=1, the entry SHALL be allocated: victim = first invalid way (way0 preferred), else the LRU way; counter=2; LRU SHALL point to the other way.
REQ-021 On an update miss with taken=0, no state SHALL change.
REQ-022 Updates SHALL commit on the clock edge, and a same-cycle lookup SHALL see pre-update contents (1-cycle write-to-read latency).
REQ-023 If both ways match (illegal), way0 SHALL be used for reads and updates.
REQ-024 The FSM SHALL have states IDLE and FLUSH: IDLE--flush-->FLUSH with sweep counter=0; in FLUSH, one set (both ways plus LRU) SHALL be cleared per cycle; after set 2**IDX_W-1 is cleared it SHALL return to IDLE; the sweep SHALL take exactly 2**IDX_W cycles.
REQ-025 busy SHALL equal (state==FLUSH).
REQ-026 An update coinciding with flush asserted, or with busy=1, SHALL be dropped.
REQ-027 flush asserted while busy=1 SHALL restart the sweep at set 0.

Reset
REQ-028 rst=1 SHALL, in one cycle, clear all valid bits, counters and LRU bits, force state=IDLE and sweep counter=0, and win over flush and update.
REQ-029 After reset, all hit/taken outputs, pred_pc1/2 and busy SHALL be 0; tag and target storage need not be cleared.
REQ-030 rst asserted mid-sweep SHALL abort the sweep and return the FSM to IDLE.

Structure
REQ-031 Package btb_pkg SHALL hold the FSM state encoding (IDLE, FLUSH) and the counter constants CTR_WEAK_TAKEN=2'b10 and CTR_MAX=2'b11.
REQ-032 The counter update SHALL be a sub-module sat_ctr2 (2-bit in, taken in, 2-bit out), instantiated once on the update path.
REQ-033 Each way's storage SHALL be a plain register array with 2 read ports and 1 write port.

Verification
REQ-034 Bench SHALL cover: rst, then lookups pc1=0x0040, pc2=0x1F40 -> hit1=hit2=0, pred_pc=0, busy=0.
REQ-035 Bench SHALL cover: update pc=0x0040, target=0x0100, taken=1, then lookup next cycle -> hit1=1, pred_taken1=1, pred_pc1=0x0100; a lookup in the same cycle as the update -> hit1=0.
REQ-036 Bench SHALL cover: three taken updates to index 0 with distinct tags A, B, C -> C evicts A (the LRU); A misses, B and C hit.
REQ-037 Bench SHALL cover: on an allocated entry (counter=2), not-taken x2 -> counter=0 and pred_taken=0 with hit=1; then taken x3 -> counter saturates at 3.
REQ-038 Bench SHALL cover: populated table, flush pulse -> busy=1 for exactly 16 cycles (IDX_W=4) with all hits=0 during the sweep; afterwards all entries miss; an update issued mid-sweep is dropped.
REQ-039 Bench SHALL cover: rst asserted at sweep cycle 5 -> busy=0 next cycle; a flush re-issued at cycle 3 of a sweep -> busy lasts 16 cycles from the re-issue.
